// File: rtl/dependence_pkg.sv
// Shared constants and helpers for the debounced three-input voter.
// Optional input synchronizers are enabled with DEPENDENCE_SYNC_EN.
package dependence_pkg;

  localparam int FILTER_LEN_MAX = 255;

  function automatic int cnt_w(input int len);
    return $clog2(len + 1);
  endfunction

  function automatic logic maj3(
    input logic x,
    input logic y,
    input logic z
  );
    return (x & y) | (x & z) | (y & z);
  endfunction

  function automatic logic par3(
    input logic x,
    input logic y,
    input logic z
  );
    return x ^ y ^ z;
  endfunction

endpackage

// File: rtl/dep_filter.sv
// Glitch filter for one raw input, with an optional two-flop
// synchronizer in front when DEPENDENCE_SYNC_EN is defined.
module dep_filter
  import dependence_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = cnt_w(FILTER_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          w_din;
  logic          r_f;
  logic [CW-1:0] r_cnt;

`ifdef DEPENDENCE_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], din};
    end
  end

  assign w_din = r_sync[1];
`else
  assign w_din = din;
`endif

  // Any return to the filtered level restarts the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f   <= 1'b0;
      r_cnt <= '0;
    end else if (w_din == r_f) begin
      r_cnt <= '0;
    end else if (r_cnt >= CNT_LAST) begin
      r_f   <= w_din;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign dout = r_f;

endmodule

// File: rtl/dependence_logic.sv
// Debounced majority/parity voter over three raw inputs.
// DEPENDENCE_SYNC_EN adds a two-flop synchronizer per input.
module dependence_logic
  import dependence_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic Result,
  output logic Q
);

  logic w_f_a;
  logic w_f_b;
  logic w_f_c;
  logic r_result;
  logic r_q;

  dep_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk  (clk),
    .rst  (rst),
    .din  (a),
    .dout (w_f_a)
  );

  dep_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk  (clk),
    .rst  (rst),
    .din  (b),
    .dout (w_f_b)
  );

  dep_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
    .clk  (clk),
    .rst  (rst),
    .din  (c),
    .dout (w_f_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= 1'b0;
      r_q      <= 1'b0;
    end else begin
      r_result <= maj3(w_f_a, w_f_b, w_f_c);
      r_q      <= par3(w_f_a, w_f_b, w_f_c);
    end
  end

  assign Result = r_result;
  assign Q      = r_q;

endmodule

// File: tb/tb_dependence_logic.sv
// Directed-vector bench for dependence_logic (FILTER_LEN=4).
// Latency widens by two edges when DEPENDENCE_SYNC_EN is defined.
module tb_dependence_logic;

  localparam int FL = 4;
`ifdef DEPENDENCE_SYNC_EN
  localparam int LAT = FL + 2;
`else
  localparam int LAT = FL;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a   = 1'b0;
  logic b   = 1'b0;
  logic c   = 1'b0;
  logic Result;
  logic Q;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] maj_tbl = 8'hE8;
  logic [7:0] par_tbl = 8'h96;

  dependence_logic #(.FILTER_LEN(FL)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .c      (c),
    .Result (Result),
    .Q      (Q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1;
    // Reset with all inputs high
    a = 1'b1; b = 1'b1; c = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_res", Result, 1'b0);
      chk("rst_q", Q, 1'b0);
    end
    rst = 1'b0;
    tick();
    chk("rel_res", Result, 1'b0);
    chk("rel_q", Q, 1'b0);

    // Step 0->1 on all inputs
    a = 1'b0; b = 1'b0; c = 1'b0;
    do_reset();
    tick();
    a = 1'b1; b = 1'b1; c = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      chk("step_early_res", Result, 1'b0);
      chk("step_early_q", Q, 1'b0);
    end
    tick();
    chk("step_res", Result, 1'b1);
    chk("step_q", Q, 1'b1);

    // Glitch of 3 cycles on a
    a = 1'b0; b = 1'b0; c = 1'b0;
    do_reset();
    a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("glitch_res", Result, 1'b0);
      chk("glitch_q", Q, 1'b0);
    end
    a = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      chk("glitch_res", Result, 1'b0);
      chk("glitch_q", Q, 1'b0);
    end

    // Majority/parity sweep over all combinations
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {a, b, c} = v;
      for (int k = 0; k < LAT + 2; k++) tick();
      chk("sweep_res", Result, maj_tbl[v]);
      chk("sweep_q", Q, par_tbl[v]);
    end

    // Restart: b high 3, low 1, high again
    a = 1'b0; b = 1'b0; c = 1'b0;
    do_reset();
    b = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    b = 1'b0;
    tick();
    b = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      chk("restart_early_q", Q, 1'b0);
    end
    tick();
    chk("restart_q", Q, 1'b1);
    chk("restart_res", Result, 1'b0);

    // Reset while a is one edge from acceptance
    a = 1'b0; b = 1'b0; c = 1'b0;
    do_reset();
    a = 1'b1;
    for (int i = 0; i < LAT - 1; i++) tick();
    rst = 1'b1;
    tick();
    chk("midrst_q", Q, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      chk("midrst_early_q", Q, 1'b0);
    end
    tick();
    chk("midrst_q_late", Q, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
